game_seq: RTL and testbench

Game-level sequencer for the Flappy-Bird datapath. It sits between the input/frame-timing logic and the bird/pipe/collision blocks. It runs the round state machine (title, play, death freeze, game over) and gates world motion with `run_en`. It filters the registered `collision` flag through a start-of-round grace window, counts pipes passed into `score`, and keeps `best_score`.

---
 rtl/game_seq.sv | 168 ++++++++++++++++
 tb/tb_game_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_seq.sv
// game_seq: round sequencer for the Flappy-Bird datapath.
//
// Runs the round state machine, gates world motion, filters collisions
// through a start-of-round grace window, counts pipes passed and keeps
// the best score since reset.
//
// Ports
//   clk, rst_n         system clock, async active-low reset
//   frame_tick         one-cycle pulse per video frame
//   btn_flap           debounced flap button level (clk domain)
//   collision          registered hit flag from the collision detector
//   bird_x             bird left edge
//   pipe1_x, pipe2_x   pipe left edges
//   state              current state (IDLE=0, PLAYING=1, DYING=2, OVER=3)
//   run_en             enables bird physics and pipe scroll
//   world_rst          one-cycle reload pulse for bird/pipe blocks
//   flap_pulse         one-cycle flap command
//   score              pipes passed this round (saturating)
//   best_score         highest score since reset
//   game_over          high in OVER
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | title screen, world frozen, waiting for a press
// PLAYING | world running, flaps forwarded, collisions after grace
// DYING   | world frozen for DEATH_FRAMES frame ticks
// OVER    | game over shown, press returns to IDLE
module game_seq #(
    parameter int PIPE_W       = 80,
    parameter int GRACE_FRAMES = 8,
    parameter int DEATH_FRAMES = 45,
    parameter int SCORE_MAX    = 999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        btn_flap,
    input  logic        collision,
    input  logic [11:0] bird_x,
    input  logic [11:0] pipe1_x,
    input  logic [11:0] pipe2_x,
    output logic [1:0]  state,
    output logic        run_en,
    output logic        world_rst,
    output logic        flap_pulse,
    output logic [9:0]  score,
    output logic [9:0]  best_score,
    output logic        game_over
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_DYING   = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    state_t      st, st_nxt;
    logic        btn_q;
    logic        press;
    logic        prev1, prev2;
    logic        passed1, passed2;
    logic        rise1, rise2;
    logic [15:0] grace_cnt, grace_nxt;
    logic [15:0] death_cnt, death_nxt;
    logic [9:0]  score_nxt, best_nxt, score_sat;
    logic [10:0] score_sum;
    logic        run_en_nxt, world_rst_nxt, flap_nxt, game_over_nxt;

    assign state = st;
    assign press = btn_flap & ~btn_q;

    // 13-bit compare so pipe_x + PIPE_W cannot wrap past the bird.
    assign passed1 = ({1'b0, pipe1_x} + 13'(PIPE_W)) < {1'b0, bird_x};
    assign passed2 = ({1'b0, pipe2_x} + 13'(PIPE_W)) < {1'b0, bird_x};
    assign rise1   = passed1 & ~prev1;
    assign rise2   = passed2 & ~prev2;

    assign score_sum = {1'b0, score} + {10'd0, rise1} + {10'd0, rise2};
    assign score_sat = (score_sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt        = st;
        grace_nxt     = grace_cnt;
        death_nxt     = death_cnt;
        score_nxt     = score;
        best_nxt      = best_score;
        world_rst_nxt = 1'b0;
        flap_nxt      = 1'b0;
        case (st)
            S_IDLE: begin
                if (press) begin
                    st_nxt        = S_PLAYING;
                    world_rst_nxt = 1'b1;
                    score_nxt     = 10'd0;
                    grace_nxt     = 16'(GRACE_FRAMES);
                end
            end
            S_PLAYING: begin
                // Positions are being reloaded during world_rst; ignore pass edges.
                if (!world_rst) score_nxt = score_sat;
                if (frame_tick && grace_cnt != 16'd0) grace_nxt = grace_cnt - 16'd1;
                if (collision && grace_cnt == 16'd0) begin
                    st_nxt    = S_DYING;
                    death_nxt = 16'(DEATH_FRAMES);
                end else if (press) begin
                    flap_nxt = 1'b1;
                end
            end
            S_DYING: begin
                if (frame_tick) begin
                    if (death_cnt <= 16'd1) begin
                        st_nxt    = S_OVER;
                        death_nxt = 16'd0;
                        if (score > best_score) best_nxt = score;
                    end else begin
                        death_nxt = death_cnt - 16'd1;
                    end
                end
            end
            S_OVER: begin
                if (press) begin
                    st_nxt        = S_IDLE;
                    world_rst_nxt = 1'b1;
                end
            end
            default: st_nxt = S_IDLE;
        endcase
        run_en_nxt    = (st_nxt == S_PLAYING);
        game_over_nxt = (st_nxt == S_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q      <= 1'b1;
            prev1      <= 1'b1;
            prev2      <= 1'b1;
            grace_cnt  <= 16'd0;
            death_cnt  <= 16'd0;
            score      <= 10'd0;
            best_score <= 10'd0;
            run_en     <= 1'b0;
            world_rst  <= 1'b0;
            flap_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            btn_q      <= btn_flap;
            // Forcing prev high while reloading keeps a pipe that starts
            // left of the bird from scoring.
            prev1      <= world_rst ? 1'b1 : passed1;
            prev2      <= world_rst ? 1'b1 : passed2;
            grace_cnt  <= grace_nxt;
            death_cnt  <= death_nxt;
            score      <= score_nxt;
            best_score <= best_nxt;
            run_en     <= run_en_nxt;
            world_rst  <= world_rst_nxt;
            flap_pulse <= flap_nxt;
            game_over  <= game_over_nxt;
        end
    end

endmodule

// File: tb/tb_game_seq.sv
module tb_game_seq;

    localparam int PIPE_W       = 80;
    localparam int GRACE_FRAMES = 8;
    localparam int DEATH_FRAMES = 45;
    localparam int SCORE_MAX    = 999;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick, btn_flap, collision;
    logic [11:0] bird_x, pipe1_x, pipe2_x;
    logic [1:0]  state;
    logic        run_en, world_rst, flap_pulse, game_over;
    logic [9:0]  score, best_score;

    int n_vec = 0;
    int n_err = 0;

    int bx = 200, p1 = 1000, p2 = 1000;

    // Reference model: round phase plus frame counts since round start / death.
    int m_phase, m_frames, m_dframes, m_score, m_best;
    bit m_btn_prev, m_prev1, m_prev2, m_wr, m_flap;

    game_seq #(
        .PIPE_W(PIPE_W), .GRACE_FRAMES(GRACE_FRAMES),
        .DEATH_FRAMES(DEATH_FRAMES), .SCORE_MAX(SCORE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_flap(btn_flap),
        .collision(collision), .bird_x(bird_x), .pipe1_x(pipe1_x), .pipe2_x(pipe2_x),
        .state(state), .run_en(run_en), .world_rst(world_rst), .flap_pulse(flap_pulse),
        .score(score), .best_score(best_score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_frames = 0; m_dframes = 0; m_score = 0; m_best = 0;
        m_btn_prev = 1; m_prev1 = 1; m_prev2 = 1; m_wr = 0; m_flap = 0;
    endtask

    task automatic model_step(input bit bf, input bit ft, input bit col);
        bit press, pass1, pass2, n_wr, n_flap;
        int n_phase, n_score, inc;
        press   = bf && !m_btn_prev;
        pass1   = (p1 + PIPE_W) < bx;
        pass2   = (p2 + PIPE_W) < bx;
        n_phase = m_phase;
        n_score = m_score;
        n_wr    = 0;
        n_flap  = 0;
        if (m_phase == 0) begin
            if (press) begin
                n_phase = 1; n_wr = 1; n_score = 0; m_frames = 0;
            end
        end else if (m_phase == 1) begin
            if (!m_wr) begin
                inc = int'(pass1 && !m_prev1) + int'(pass2 && !m_prev2);
                n_score = (m_score + inc > SCORE_MAX) ? SCORE_MAX : m_score + inc;
            end
            if (col && m_frames >= GRACE_FRAMES) begin
                n_phase = 2; m_dframes = 0;
            end else if (press) begin
                n_flap = 1;
            end
            if (ft) m_frames++;
        end else if (m_phase == 2) begin
            if (ft) begin
                m_dframes++;
                if (m_dframes >= DEATH_FRAMES) begin
                    n_phase = 3;
                    if (m_score > m_best) m_best = m_score;
                end
            end
        end else begin
            if (press) begin
                n_phase = 0; n_wr = 1;
            end
        end
        m_prev1    = m_wr ? 1'b1 : pass1;
        m_prev2    = m_wr ? 1'b1 : pass2;
        m_btn_prev = bf;
        m_phase    = n_phase;
        m_score    = n_score;
        m_wr       = n_wr;
        m_flap     = n_flap;
    endtask

    task automatic compare_all();
        check_eq("state",      int'(state),      m_phase);
        check_eq("run_en",     int'(run_en),     int'(m_phase == 1));
        check_eq("world_rst",  int'(world_rst),  int'(m_wr));
        check_eq("flap_pulse", int'(flap_pulse), int'(m_flap));
        check_eq("score",      int'(score),      m_score);
        check_eq("best_score", int'(best_score), m_best);
        check_eq("game_over",  int'(game_over),  int'(m_phase == 3));
    endtask

    task automatic check_reset_values();
        check_eq("rst_state",     int'(state),      0);
        check_eq("rst_run_en",    int'(run_en),     0);
        check_eq("rst_world_rst", int'(world_rst),  0);
        check_eq("rst_flap",      int'(flap_pulse), 0);
        check_eq("rst_score",     int'(score),      0);
        check_eq("rst_best",      int'(best_score), 0);
        check_eq("rst_game_over", int'(game_over),  0);
    endtask

    task automatic tick(input bit bf, input bit ft, input bit col);
        btn_flap   = bf;
        frame_tick = ft;
        collision  = col;
        bird_x     = 12'(bx);
        pipe1_x    = 12'(p1);
        pipe2_x    = 12'(p2);
        model_step(bf, ft, col);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic start_round();
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
    endtask

    task automatic pass_one();
        p1 = 1000; tick(0, 0, 0);
        p1 = 100;  tick(0, 0, 0);
    endtask

    task automatic finish_round();
        repeat (GRACE_FRAMES) tick(0, 1, 0);
        tick(0, 0, 1);
        repeat (DEATH_FRAMES) tick(0, 1, 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 0; btn_flap = 0; collision = 0;
        bird_x = 12'd200; pipe1_x = 12'd1000; pipe2_x = 12'd1000;
        #12;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Start press: world_rst + PLAYING one cycle later, no flap.
        tick(0, 0, 0);
        tick(1, 0, 0);
        check_eq("start_state", int'(state), 1);
        check_eq("start_wr", int'(world_rst), 1);
        check_eq("start_run", int'(run_en), 1);
        check_eq("start_noflap", int'(flap_pulse), 0);
        tick(1, 0, 0);
        check_eq("wr_one_cycle", int'(world_rst), 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
        check_eq("flap_hi", int'(flap_pulse), 1);
        tick(1, 0, 0);
        check_eq("flap_one_cycle", int'(flap_pulse), 0);
        tick(0, 0, 0);

        // Collisions inside the grace window are ignored.
        repeat (GRACE_FRAMES) begin
            tick(0, 1, 1);
            tick(0, 0, 0);
        end
        check_eq("grace_hold", int'(state), 1);

        // Pipe sweep past bird at 200: crossing at 119.
        for (int x = 200; x >= 100; x--) begin
            p1 = x;
            tick(0, 0, 0);
        end
        check_eq("sweep1", int'(score), 1);
        p1 = 1000; tick(0, 0, 0);
        for (int x = 200; x >= 100; x--) begin
            p1 = x;
            tick(0, 0, 0);
        end
        check_eq("sweep2", int'(score), 2);
        p1 = 1000; p2 = 1000; tick(0, 0, 0);
        p1 = 100;  p2 = 100;  tick(0, 0, 0);
        check_eq("double_pass", int'(score), 4);

        // Collision with a simultaneous press: DYING, no flap.
        tick(1, 0, 1);
        check_eq("die_state", int'(state), 2);
        check_eq("die_noflap", int'(flap_pulse), 0);
        check_eq("die_run", int'(run_en), 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
        check_eq("dying_press", int'(state), 2);
        tick(0, 0, 0);
        repeat (DEATH_FRAMES - 1) tick(0, 1, 0);
        check_eq("dying_len", int'(state), 2);
        tick(0, 1, 0);
        check_eq("over_state", int'(state), 3);
        check_eq("over_flag", int'(game_over), 1);
        check_eq("best_r1", int'(best_score), 4);
        tick(0, 0, 0);
        tick(1, 0, 0);
        check_eq("over_to_idle", int'(state), 0);
        check_eq("over_wr", int'(world_rst), 1);
        check_eq("score_kept", int'(score), 4);
        tick(0, 0, 0);

        // Round 2 scores 5 -> best rises; round 3 scores 2 -> best held.
        start_round();
        repeat (5) pass_one();
        finish_round();
        check_eq("best_r2", int'(best_score), 5);
        start_round();
        repeat (2) pass_one();
        finish_round();
        check_eq("best_r3", int'(best_score), 5);

        // Saturation at SCORE_MAX.
        start_round();
        repeat (500) begin
            p1 = 1000; p2 = 1000; tick(0, 0, 0);
            p1 = 100;  p2 = 100;  tick(0, 0, 0);
        end
        check_eq("sat", int'(score), SCORE_MAX);
        p1 = 1000; tick(0, 0, 0);
        p1 = 100;  tick(0, 0, 0);
        check_eq("sat_hold", int'(score), SCORE_MAX);

        // Reset mid-round.
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bx = $urandom_range(100, 400);
            p1 = $urandom_range(0, 1100);
            p2 = ($urandom_range(0, 1) == 0) ? p2 : $urandom_range(0, 1100);
            tick(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 3) == 0),
                 bit'($urandom_range(0, 9) == 0));
            if (i == 2000) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
